// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter and sequencer that shares one single-port data memory between
// the core load/store path (master 0) and the I2C transfer engine (master 1).
module dmem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int NM = 2;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_reg, state_next;
    logic              last_grant_reg, last_grant_next;
    logic              id_reg, id_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_reg, err_next;

    logic [NM-1:0]     req_vec, we_vec, ack_vec, err_vec;
    logic [ADDR_W-1:0] addr_arr  [NM];
    logic [DATA_W-1:0] wdata_arr [NM];
    logic [DATA_W-1:0] rdata_arr [NM];

    assign req_vec      = {m1_req, m0_req};
    assign we_vec       = {m1_we, m0_we};
    assign addr_arr[0]  = m0_addr;
    assign addr_arr[1]  = m1_addr;
    assign wdata_arr[0] = m0_wdata;
    assign wdata_arr[1] = m1_wdata;

    // Master 1 wins only if it is alone or master 0 was served last.
    logic any_req, gnt_id, bad_addr;
    assign any_req  = |req_vec;
    assign gnt_id   = req_vec[1] & (~req_vec[0] | ~last_grant_reg);
    assign bad_addr = (addr_arr[gnt_id][1:0] != 2'b00) || (addr_arr[gnt_id] > MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            id_reg         <= id_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        id_next         = id_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        err_next        = err_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    id_next         = gnt_id;
                    we_next         = we_vec[gnt_id];
                    addr_next       = addr_arr[gnt_id];
                    wdata_next      = wdata_arr[gnt_id];
                    last_grant_next = gnt_id;
                    rdata_next      = '0;
                    err_next        = bad_addr;
                    state_next      = bad_addr ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                // Captured on writes too, so a write returns the overwritten word.
                rdata_next = mem_rdata;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory port is only driven during ACCESS so reset drops mem_we at once.
    assign mem_we    = (state_reg == ACCESS) & we_reg;
    assign mem_addr  = (state_reg == ACCESS) ? addr_reg  : '0;
    assign mem_wdata = (state_reg == ACCESS) ? wdata_reg : '0;

    generate
        for (genvar gi = 0; gi < NM; gi++) begin : g_resp
            assign ack_vec[gi]   = (state_reg == DONE) && (id_reg == 1'(gi));
            assign err_vec[gi]   = ack_vec[gi] & err_reg;
            assign rdata_arr[gi] = ack_vec[gi] ? rdata_reg : '0;
        end
    endgenerate

    assign m0_ack   = ack_vec[0];
    assign m1_ack   = ack_vec[1];
    assign m0_err   = err_vec[0];
    assign m1_err   = err_vec[1];
    assign m0_rdata = rdata_arr[0];
    assign m1_rdata = rdata_arr[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a 64-byte behavioural memory on the memory port and a
// transaction-level model (word array, round-robin pointer, latency rules) predicting responses.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
    localparam int MB = 64;
    localparam int NW = MB / 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT; preload port used only while the DUT is in reset.
    logic [31:0] env_mem [NW];
    logic        preload = 1'b0;
    logic [3:0]  preload_idx = 4'd0;
    logic [31:0] preload_val = 32'd0;
    always @(posedge clk) begin
        if (preload) env_mem[preload_idx] <= preload_val;
        else if (mem_we) env_mem[mem_addr[5:2]] <= mem_wdata;
    end
    assign mem_rdata = env_mem[mem_addr[5:2]];

    // Reference model state.
    logic [31:0] ref_mem [NW];
    int          ref_last;
    bit          act    [2];
    bit          rq_we  [2];
    logic [31:0] rq_addr  [2];
    logic [31:0] rq_wdata [2];
    logic [31:0] last_rdata;
    int          checks = 0;
    int          failures = 0;
    int          txn_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {27'd0, m0_ack, m1_ack, m0_err, m1_err, mem_we}, 32'd0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic apply(input int m);
        if (m == 0) begin
            m0_req = act[0]; m0_we = rq_we[0]; m0_addr = rq_addr[0]; m0_wdata = rq_wdata[0];
        end else begin
            m1_req = act[1]; m1_we = rq_we[1]; m1_addr = rq_addr[1]; m1_wdata = rq_wdata[1];
        end
    endtask

    task automatic scramble(input int m);
        if (m == 0) begin
            m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
        end else begin
            m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
        end
    endtask

    task automatic set_req(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        act[m] = 1'b1; rq_we[m] = we; rq_addr[m] = addr; rq_wdata[m] = wdata;
        apply(m);
    endtask

    task automatic rand_req(input int m);
        int sel;
        logic [31:0] a;
        sel = int'($urandom_range(0, 9));
        if (sel < 7)       a = 32'($urandom_range(0, NW - 1)) * 32'd4;
        else if (sel == 7) a = 32'($urandom_range(0, NW - 1)) * 32'd4 + 32'($urandom_range(1, 3));
        else if (sel == 8) a = 32'($urandom_range(MB - 3, 255));
        else               a = $urandom;
        set_req(m, 1'($urandom), a, $urandom);
    endtask

    // Caller has just driven the requests at a falling edge; each grant is predicted
    // from round-robin order and the 2-cycle (valid) / 1-cycle (error) ack latency.
    task automatic run_grants(input int n, input bit regen, input bit scr);
        int w, lat;
        bit e;
        logic [31:0] exp_rd, obs_rd, obs_err;
        for (int g = 0; g < n; g++) begin
            if (act[0] && act[1]) w = 1 - ref_last;
            else if (act[0])      w = 0;
            else                  w = 1;
            e      = (rq_addr[w][1:0] != 2'b00) || (rq_addr[w] > 32'(MB - 4));
            lat    = e ? 1 : 2;
            exp_rd = e ? 32'd0 : ref_mem[rq_addr[w][5:2]];
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                if (!e && k == 1) begin
                    chk("mem_we_access", 32'(mem_we), 32'(rq_we[w]));
                    chk("mem_addr_access", mem_addr, rq_addr[w]);
                    chk("mem_wdata_access", mem_wdata, rq_wdata[w]);
                end else begin
                    chk("mem_we_off", 32'(mem_we), 32'd0);
                end
                chk("m0_ack", 32'(m0_ack), 32'(k == lat && w == 0));
                chk("m1_ack", 32'(m1_ack), 32'(k == lat && w == 1));
                if (scr && k == 1 && lat == 2) scramble(w);
            end
            obs_rd  = (w == 0) ? m0_rdata : m1_rdata;
            obs_err = (w == 0) ? 32'(m0_err) : 32'(m1_err);
            chk("resp_err", obs_err, 32'(e));
            chk("resp_rdata", obs_rd, exp_rd);
            last_rdata = obs_rd;
            $display("txn %0d: m%0d %s addr=0x%08h wdata=0x%08h err=%0d rdata=0x%08h",
                     txn_no, w, rq_we[w] ? "wr" : "rd", rq_addr[w], rq_wdata[w], obs_err, obs_rd);
            txn_no++;
            if (!e && rq_we[w]) ref_mem[rq_addr[w][5:2]] = rq_wdata[w];
            ref_last = w;
            if (g == n - 1) begin
                act[0] = 1'b0; act[1] = 1'b0;
            end else if (regen) begin
                rand_req(w);
            end
            apply(0); apply(1);
            @(negedge clk);
            chk("idle_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
            chk("idle_mem_we", 32'(mem_we), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        act[0] = 1'b0; act[1] = 1'b0;
        for (int m = 0; m < 2; m++) begin
            rq_we[m] = 1'b0; rq_addr[m] = 32'd0; rq_wdata[m] = 32'd0;
            apply(m);
        end
        ref_last = 1;
        last_rdata = 32'd0;
        rst_n = 1'b0;

        // Reset held: preload memory, toggle every input, outputs must stay 0.
        preload = 1'b1;
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            preload_idx = 4'(i);
            preload_val = (i == 0) ? 32'h1234_5678 : $urandom;
            ref_mem[i]  = preload_val;
            m0_req = 1'($urandom); m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
            m1_req = 1'($urandom); m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
            #1 check_zero("reset");
        end
        @(negedge clk);
        preload = 1'b0;
        apply(0); apply(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        // Write then cross-master read-back.
        set_req(0, 1'b1, 32'd8, 32'hDEAD_BEEF);
        run_grants(1, 1'b0, 1'b0);
        set_req(1, 1'b0, 32'd8, 32'd0);
        run_grants(1, 1'b0, 1'b0);
        chk("readback_value", last_rdata, 32'hDEAD_BEEF);

        // Contention: both reads held, grants alternate starting with m0.
        set_req(0, 1'b0, 32'd4, 32'd0);
        set_req(1, 1'b0, 32'd12, 32'd0);
        run_grants(4, 1'b0, 1'b0);

        // Error responses and the upper address boundary.
        set_req(0, 1'b1, 32'd6, 32'hCAFE_F00D);
        run_grants(1, 1'b0, 1'b0);
        set_req(1, 1'b0, 32'd61, 32'd0);
        run_grants(1, 1'b0, 1'b0);
        set_req(1, 1'b0, 32'd60, 32'd0);
        run_grants(1, 1'b0, 1'b0);

        // Reset during ACCESS of a write to addr 0: write lost, no ack.
        set_req(0, 1'b1, 32'd0, 32'hA5A5_0F0F);
        @(negedge clk);
        chk("midop_mem_we_before", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1 check_zero("midop_reset");
        act[0] = 1'b0; apply(0);
        @(negedge clk);
        check_zero("midop_hold");
        rst_n = 1'b1;
        ref_last = 1;
        @(negedge clk);
        check_zero("midop_release");
        set_req(0, 1'b0, 32'd0, 32'd0);
        run_grants(1, 1'b0, 1'b0);
        chk("midop_prior_contents", last_rdata, 32'h1234_5678);

        // Back-to-back: m0 held across 3 grants with m1 idle.
        set_req(0, 1'b0, 32'd16, 32'd0);
        run_grants(3, 1'b0, 1'b0);

        // Randomized mix with back-to-back re-requests and input churn after grant.
        for (int r = 0; r < 25; r++) begin
            int mask;
            mask = int'($urandom_range(1, 3));
            if (mask[0]) rand_req(0);
            if (mask[1]) rand_req(1);
            run_grants(int'($urandom_range(1, 6)), 1'b1, 1'b1);
        end

        // Final sweep: read every word and compare with the model.
        for (int i = 0; i < NW; i++) begin
            set_req(i % 2, 1'b0, 32'(i * 4), 32'd0);
            run_grants(1, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
